// File: rtl/touch_key_gen.sv
// Touch-key stimulus generator: on start, emits a burst of active-low
// presses with programmable press width, release gap and count.
module touch_key_gen #(
  parameter int CNT_W = 16,
  parameter int NUM_W = 8
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] press_len,
  input  logic [CNT_W-1:0] gap_len,
  input  logic [NUM_W-1:0] press_num,
  output logic             touch_key,
  output logic             busy,
  output logic             done,
  output logic [NUM_W-1:0] press_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    PRESS,
    GAP,
    FIN
  } state_e;

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] plen_q, plen_d;
  logic [CNT_W-1:0] glen_q, glen_d;
  logic [NUM_W-1:0] num_q, num_d;
  logic [NUM_W-1:0] pcnt_q, pcnt_d;
  logic             key_q, key_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] plen_in, glen_in;
  logic [NUM_W-1:0] pcnt_inc;

  always_comb begin
    // zero lengths behave as one cycle
    plen_in  = (press_len == '0) ? ONE : press_len;
    glen_in  = (gap_len == '0) ? ONE : gap_len;
    pcnt_inc = pcnt_q + 1'b1;

    state_d = state_q;
    cnt_d   = cnt_q;
    plen_d  = plen_q;
    glen_d  = glen_q;
    num_d   = num_q;
    pcnt_d  = pcnt_q;
    key_d   = key_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        key_d  = 1'b1;
        busy_d = 1'b0;
        if (start) begin
          plen_d = plen_in;
          glen_d = glen_in;
          num_d  = press_num;
          pcnt_d = '0;
          cnt_d  = plen_in - 1'b1;
          if (press_num == '0) begin
            state_d = FIN;
            done_d  = 1'b1;
          end else begin
            state_d = PRESS;
            key_d   = 1'b0;
            busy_d  = 1'b1;
          end
        end
      end
      PRESS: begin
        if (abort) begin
          state_d = FIN;
          key_d   = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else if (cnt_q == '0) begin
          pcnt_d = pcnt_inc;
          key_d  = 1'b1;
          if (pcnt_inc == num_q) begin
            state_d = FIN;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = GAP;
            cnt_d   = glen_q - 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      GAP: begin
        if (abort) begin
          state_d = FIN;
          key_d   = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else if (cnt_q == '0) begin
          state_d = PRESS;
          key_d   = 1'b0;
          cnt_d   = plen_q - 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      FIN: begin
        state_d = IDLE;
        key_d   = 1'b1;
        busy_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      plen_q  <= '0;
      glen_q  <= '0;
      num_q   <= '0;
      pcnt_q  <= '0;
      key_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      plen_q  <= plen_d;
      glen_q  <= glen_d;
      num_q   <= num_d;
      pcnt_q  <= pcnt_d;
      key_q   <= key_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign touch_key = key_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign press_cnt = pcnt_q;

endmodule

// File: tb/tb_touch_key_gen.sv
// Randomized bench for touch_key_gen against a per-cycle waveform
// model built from burst parameters.
module tb_touch_key_gen;

  logic        sys_clk;
  logic        sys_rst;
  logic        start;
  logic        abort;
  logic [15:0] press_len;
  logic [15:0] gap_len;
  logic [7:0]  press_num;
  logic        touch_key;
  logic        busy;
  logic        done;
  logic [7:0]  press_cnt;

  int n_cmp;
  int n_bad;

  touch_key_gen #(
    .CNT_W(16),
    .NUM_W(8)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .start    (start),
    .abort    (abort),
    .press_len(press_len),
    .gap_len  (gap_len),
    .press_num(press_num),
    .touch_key(touch_key),
    .busy     (busy),
    .done     (done),
    .press_cnt(press_cnt)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  function automatic logic [10:0] pack(
    input logic tk, input logic b,
    input logic d, input logic [7:0] c);
    return {tk, b, d, c};
  endfunction

  function automatic logic [10:0] obs();
    return pack(touch_key, busy, done, press_cnt);
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic scramble();
    press_len = 16'($urandom_range(0, 9));
    gap_len   = 16'($urandom_range(0, 9));
    press_num = 8'($urandom_range(0, 6));
  endtask

  // One burst; abort_k is the trace index during which abort is held
  // (ignored when negative or outside the busy span).
  task automatic run_burst(input int pl, input int gl,
                           input int pn, input int abort_k);
    logic [10:0] q[$];
    int pe, ge, nb;
    logic [7:0] fc;
    pe = (pl == 0) ? 1 : pl;
    ge = (gl == 0) ? 1 : gl;
    for (int p = 0; p < pn; p++) begin
      for (int c = 0; c < pe; c++)
        q.push_back(pack(1'b0, 1'b1, 1'b0, 8'(p)));
      if (p < pn - 1)
        for (int c = 0; c < ge; c++)
          q.push_back(pack(1'b1, 1'b1, 1'b0, 8'(p + 1)));
    end
    nb = q.size();
    fc = 8'(pn);
    if (abort_k >= 0 && abort_k < nb) begin
      fc = q[abort_k][7:0];
      while (q.size() > abort_k + 1) void'(q.pop_back());
    end else begin
      abort_k = -1;
    end
    q.push_back(pack(1'b1, 1'b0, 1'b1, fc));

    press_len = 16'(pl);
    gap_len   = 16'(gl);
    press_num = 8'(pn);
    start     = 1'b1;
    abort     = 1'($urandom_range(0, 1));
    tick();
    for (int i = 0; i < q.size(); i++) begin
      chk("burst", 32'(obs()), 32'(q[i]));
      scramble();
      start = (i < q.size() - 1) ? ($urandom_range(0, 3) == 0) : 1'b0;
      abort = (i == abort_k);
      if (i == q.size() - 1) abort = 1'($urandom_range(0, 1));
      tick();
    end
    chk("idle0", 32'(obs()), 32'(pack(1'b1, 1'b0, 1'b0, fc)));
    abort = 1'b1;
    tick();
    chk("idle1", 32'(obs()), 32'(pack(1'b1, 1'b0, 1'b0, fc)));
    abort = 1'b0;
  endtask

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    sys_rst   = 1'b1;
    start     = 1'b0;
    abort     = 1'b0;
    press_len = '0;
    gap_len   = '0;
    press_num = '0;
    #1;
    chk("reset", 32'(obs()), 32'(pack(1'b1, 1'b0, 1'b0, 8'd0)));
    repeat (2) @(negedge sys_clk);
    sys_rst = 1'b0;
    tick();
    chk("post_rst", 32'(obs()), 32'(pack(1'b1, 1'b0, 1'b0, 8'd0)));

    run_burst(5, 3, 2, -1);
    run_burst(7, 2, 0, -1);
    run_burst(0, 0, 3, -1);
    run_burst(10, 4, 4, 16);
    run_burst(2, 1, 3, 0);
    run_burst(3, 2, 2, 4);

    // reset in the middle of a press: immediate idle, no done
    press_len = 16'd8;
    gap_len   = 16'd2;
    press_num = 8'd3;
    start     = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) @(posedge sys_clk);
    #3;
    sys_rst = 1'b1;
    #1;
    chk("rst_mid", 32'(obs()), 32'(pack(1'b1, 1'b0, 1'b0, 8'd0)));
    @(negedge sys_clk);
    sys_rst = 1'b0;
    tick();
    chk("rst_rel", 32'(obs()), 32'(pack(1'b1, 1'b0, 1'b0, 8'd0)));
    run_burst(4, 2, 2, -1);

    for (int b = 0; b < 40; b++) begin
      run_burst($urandom_range(0, 6), $urandom_range(0, 6),
                $urandom_range(0, 5),
                ($urandom_range(0, 2) == 0) ? $urandom_range(0, 40) : -1);
    end

    run_burst(65535, 0, 1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
